// File: rtl/alu_pkg.sv
// Shared constants for the Hack-style ALU: ctrl bit positions, function codes
// and the stage-1 payload layout.
package alu_pkg;

    localparam int CTRL_ZX = 5;
    localparam int CTRL_NX = 4;
    localparam int CTRL_ZY = 3;
    localparam int CTRL_NY = 2;
    localparam int CTRL_F  = 1;
    localparam int CTRL_NO = 0;

    localparam logic [5:0] ALU_ZERO      = 6'b101010;
    localparam logic [5:0] ALU_ONE       = 6'b111111;
    localparam logic [5:0] ALU_NEG_ONE   = 6'b111010;
    localparam logic [5:0] ALU_X         = 6'b001100;
    localparam logic [5:0] ALU_Y         = 6'b110000;
    localparam logic [5:0] ALU_NOT_X     = 6'b001101;
    localparam logic [5:0] ALU_NEG_X     = 6'b001111;
    localparam logic [5:0] ALU_X_PLUS_1  = 6'b011111;
    localparam logic [5:0] ALU_X_MINUS_1 = 6'b001110;
    localparam logic [5:0] ALU_X_PLUS_Y  = 6'b000010;
    localparam logic [5:0] ALU_X_MINUS_Y = 6'b010011;
    localparam logic [5:0] ALU_Y_MINUS_X = 6'b000111;
    localparam logic [5:0] ALU_X_AND_Y   = 6'b000000;
    localparam logic [5:0] ALU_X_OR_Y    = 6'b010101;

    // Preset operands plus the two controls still needed by stage 2.
    typedef struct packed {
        logic [15:0] xp;
        logic [15:0] yp;
        logic        f;
        logic        no;
    } s1_payload_t;

endpackage

// File: rtl/alu_16bit_core.sv
// Stage-2 combinational datapath: add/and select, optional output inversion,
// and the zr/ng flags of the final result.
module alu_16bit_core (
    input  logic [15:0] xp,
    input  logic [15:0] yp,
    input  logic        f,
    input  logic        no,
    output logic [15:0] res,
    output logic        zr,
    output logic        ng
);

    logic [15:0] r;
    logic [15:0] r_n;

    // Carry out of the add is intentionally dropped (mod 2^16).
    assign r = f ? (xp + yp) : (xp & yp);

    not_16bit_chip u_not_no (
        .a (r),
        .y (r_n)
    );

    assign res = no ? r_n : r;
    assign zr  = (res == 16'h0000);
    assign ng  = res[15];

endmodule

// File: rtl/not_16bit_chip.sv
// 16-bit bitwise inverter, the shared building block for all ALU inversions.
module not_16bit_chip (
    input  logic [15:0] a,
    output logic [15:0] y
);

    assign y = ~a;

endmodule

// File: rtl/alu_16bit_pipe_chip.sv
// Two-stage valid/ready pipelined Hack ALU: S1 registers preset operands,
// S2 registers the result and flags.
module alu_16bit_pipe_chip
    import alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       ctrl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             zr,
    output logic             ng
);

    s1_payload_t s1_d, s1_q;
    logic        s1_v_d, s1_v_q;
    logic        s2_v_d, s2_v_q;
    logic [15:0] out_d, out_q;
    logic        zr_d, zr_q;
    logic        ng_d, ng_q;

    logic        s1_adv, s2_adv;
    logic [15:0] x_z, x_zn, y_z, y_zn;
    logic [15:0] core_res;
    logic        core_zr, core_ng;

    assign s2_adv   = !s2_v_q || out_ready;
    assign s1_adv   = !s1_v_q || s2_adv;
    assign in_ready = s1_adv && rst_n;

    assign x_z = ctrl[CTRL_ZX] ? 16'h0000 : x;
    assign y_z = ctrl[CTRL_ZY] ? 16'h0000 : y;

    not_16bit_chip u_not_nx (
        .a (x_z),
        .y (x_zn)
    );

    not_16bit_chip u_not_ny (
        .a (y_z),
        .y (y_zn)
    );

    alu_16bit_core u_core (
        .xp  (s1_q.xp),
        .yp  (s1_q.yp),
        .f   (s1_q.f),
        .no  (s1_q.no),
        .res (core_res),
        .zr  (core_zr),
        .ng  (core_ng)
    );

    always_comb begin
        // NOTE: every _d starts as its held value so no path leaves one unassigned (no latch).
        s1_d   = s1_q;
        s1_v_d = s1_v_q;
        s2_v_d = s2_v_q;
        out_d  = out_q;
        zr_d   = zr_q;
        ng_d   = ng_q;
        if (s1_adv) begin
            s1_v_d  = in_valid;
            s1_d.xp = ctrl[CTRL_NX] ? x_zn : x_z;
            s1_d.yp = ctrl[CTRL_NY] ? y_zn : y_z;
            s1_d.f  = ctrl[CTRL_F];
            s1_d.no = ctrl[CTRL_NO];
        end
        if (s2_adv) begin
            s2_v_d = s1_v_q;
            out_d  = core_res;
            zr_d   = core_zr;
            ng_d   = core_ng;
        end
    end

    // NOTE: payload registers are reset too, because out/zr/ng must read 0 while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q   <= '0;
            s1_v_q <= 1'b0;
            s2_v_q <= 1'b0;
            out_q  <= '0;
            zr_q   <= 1'b0;
            ng_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop updates from pre-edge values.
            s1_q   <= s1_d;
            s1_v_q <= s1_v_d;
            s2_v_q <= s2_v_d;
            out_q  <= out_d;
            zr_q   <= zr_d;
            ng_q   <= ng_d;
        end
    end

    assign out_valid = s2_v_q;
    assign out       = out_q;
    assign zr        = zr_q;
    assign ng        = ng_q;

endmodule
